// File: rtl/mo_line_scheduler.sv
// rtl/mo_line_scheduler.sv - per-scanline motion-object scheduler with match FIFO
module mo_line_scheduler #(
    parameter int NUM_OBJ      = 32,
    parameter int MAX_PER_LINE = 8
) (
    input  logic       CK1,
    input  logic       RESETn,
    input  logic       HSTART,
    input  logic [7:0] VC,
    input  logic       PLAYER2,
    output logic       OBJ_REQ,
    output logic [4:0] OBJ_ADDR,
    input  logic       OBJ_ACK,
    input  logic [7:0] OBJ_Y,
    input  logic [7:0] OBJ_PIC,
    input  logic [7:0] OBJ_X,
    output logic       Q_VALID,
    input  logic       Q_READY,
    output logic [7:0] Q_PIC,
    output logic [7:0] Q_X,
    output logic [3:0] Q_ROW,
    output logic       BUSY,
    output logic       DONE,
    output logic       OVERFLOW,
    output logic       LATE
);
    localparam int PW = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
    localparam int CW = $clog2(MAX_PER_LINE + 1);
    localparam logic [4:0]    LAST_IDX = 5'(NUM_OBJ - 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_PER_LINE - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_PER_LINE);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EVAL, S_FIN} state_t;

    state_t        state, state_next;
    logic [7:0]    vc_l;
    logic          flip_l;
    logic [4:0]    idx;
    logic [7:0]    y_c, pic_c, x_c;
    logic [19:0]   mem [MAX_PER_LINE];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0] count;
    logic          overflow, late;
    logic [19:0]   head_q, head_next, push_data;
    logic          start, late_set, capture, push, ovf_set, idx_inc, pop;
    logic [7:0]    sum;
    logic [3:0]    row;
    logic          match, full;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Y is stored complemented, so VC + Y lands in 0xF0..0xFF on the object's 16 rows
    assign sum       = vc_l + y_c;
    assign match     = (sum[7:4] == 4'hF);
    assign row       = sum[3:0] ^ {4{flip_l}};
    assign full      = (count == FULL_CNT);
    assign push_data = {pic_c, x_c, row};

    always_comb begin
        state_next = state;
        start      = 1'b0;
        late_set   = 1'b0;
        capture    = 1'b0;
        push       = 1'b0;
        ovf_set    = 1'b0;
        idx_inc    = 1'b0;
        case (state)
            S_IDLE, S_FIN: begin
                state_next = S_IDLE;
                if (HSTART) begin
                    start      = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (HSTART) begin
                    start    = 1'b1;
                    late_set = 1'b1;
                end else if (OBJ_ACK) begin
                    capture    = 1'b1;
                    state_next = S_EVAL;
                end
            end
            S_EVAL: begin
                if (HSTART) begin
                    start      = 1'b1;
                    late_set   = 1'b1;
                    state_next = S_FETCH;
                end else if (match && full) begin
                    ovf_set    = 1'b1;
                    state_next = S_FIN;
                end else begin
                    push = match;
                    if (idx == LAST_IDX) begin
                        state_next = S_FIN;
                    end else begin
                        idx_inc    = 1'b1;
                        state_next = S_FETCH;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // A flush on start wins over any pop presented in the same cycle
    assign pop       = (count != '0) && Q_READY && !start;
    assign rd_next   = pop ? ptr_inc(rd_ptr) : rd_ptr;
    assign head_next = (push && (wr_ptr == rd_next)) ? push_data : mem[rd_next];

    always_ff @(posedge CK1 or negedge RESETn) begin
        if (!RESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CK1 or negedge RESETn) begin
        if (!RESETn) begin
            vc_l     <= '0;
            flip_l   <= 1'b0;
            idx      <= '0;
            y_c      <= '0;
            pic_c    <= '0;
            x_c      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            late     <= 1'b0;
            head_q   <= '0;
        end else if (start) begin
            vc_l     <= VC;
            flip_l   <= PLAYER2;
            idx      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            late     <= late_set;
        end else begin
            if (capture) begin
                y_c   <= OBJ_Y;
                pic_c <= OBJ_PIC;
                x_c   <= OBJ_X;
            end
            if (idx_inc) idx <= idx + 5'd1;
            if (ovf_set) overflow <= 1'b1;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            rd_ptr <= rd_next;
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            // Head register only follows the FIFO while it stays non-empty
            if (push || (count > CW'(1)) || ((count == CW'(1)) && !pop)) begin
                head_q <= head_next;
            end
        end
    end

    always_ff @(posedge CK1) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign OBJ_REQ              = (state == S_FETCH);
    assign OBJ_ADDR             = OBJ_REQ ? (idx ^ {5{flip_l}}) : 5'd0;
    assign BUSY                 = (state == S_FETCH) || (state == S_EVAL);
    assign DONE                 = (state == S_FIN);
    assign Q_VALID              = (count != '0);
    assign {Q_PIC, Q_X, Q_ROW}  = head_q;
    assign OVERFLOW             = overflow;
    assign LATE                 = late;
endmodule

// File: tb/tb_mo_line_scheduler.sv
// tb/tb_mo_line_scheduler.sv - self-checking bench for mo_line_scheduler
module tb_mo_line_scheduler;
    logic       CK1 = 1'b0;
    logic       RESETn, HSTART, PLAYER2, OBJ_ACK, Q_READY;
    logic [7:0] VC, OBJ_Y, OBJ_PIC, OBJ_X, Q_PIC, Q_X;
    logic [4:0] OBJ_ADDR;
    logic [3:0] Q_ROW;
    logic       OBJ_REQ, Q_VALID, BUSY, DONE, OVERFLOW, LATE;

    mo_line_scheduler #(.NUM_OBJ(32), .MAX_PER_LINE(8)) dut (
        .CK1(CK1), .RESETn(RESETn), .HSTART(HSTART), .VC(VC), .PLAYER2(PLAYER2),
        .OBJ_REQ(OBJ_REQ), .OBJ_ADDR(OBJ_ADDR), .OBJ_ACK(OBJ_ACK),
        .OBJ_Y(OBJ_Y), .OBJ_PIC(OBJ_PIC), .OBJ_X(OBJ_X),
        .Q_VALID(Q_VALID), .Q_READY(Q_READY), .Q_PIC(Q_PIC), .Q_X(Q_X), .Q_ROW(Q_ROW),
        .BUSY(BUSY), .DONE(DONE), .OVERFLOW(OVERFLOW), .LATE(LATE)
    );

    always #5 CK1 = ~CK1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ack_wait = 0;
    int wcnt;

    logic [7:0] ram_y [32];
    logic [7:0] ram_pic [32];
    logic [7:0] ram_x [32];

    assign OBJ_Y   = ram_y[OBJ_ADDR];
    assign OBJ_PIC = ram_pic[OBJ_ADDR];
    assign OBJ_X   = ram_x[OBJ_ADDR];
    assign OBJ_ACK = OBJ_REQ && (wcnt == ack_wait);

    always @(posedge CK1) cyc <= cyc + 1;

    always @(posedge CK1 or negedge RESETn) begin
        if (!RESETn) wcnt <= 0;
        else if (OBJ_REQ && !OBJ_ACK) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    // Line model: expected entries, requested addresses and completion edge
    logic [19:0] mq [$];
    logic [4:0]  aq [$];
    logic        ovf_m = 1'b0;
    logic        late_m = 1'b0;
    logic        active = 1'b0;
    int          line_k = 0;
    int          exp_done = 0;
    int          pops = 0;
    logic [3:0]  obs_row = '0;
    int          max_a = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic build_model(input logic [7:0] vc, input logic fl);
        logic [7:0] s;
        logic [4:0] a;
        mq.delete();
        aq.delete();
        ovf_m = 1'b0;
        for (int i = 0; i < 32; i++) begin
            a = 5'(i) ^ {5{fl}};
            aq.push_back(a);
            s = vc + ram_y[a];
            if (s[7:4] == 4'hF) begin
                if (mq.size() == 8) begin
                    ovf_m = 1'b1;
                    break;
                end
                mq.push_back({ram_pic[a], ram_x[a], s[3:0] ^ {4{fl}}});
            end
        end
        line_k   = cyc + 1;
        exp_done = line_k + aq.size() * (2 + ack_wait);
    endtask

    always @(negedge CK1) begin
        logic busy_m;
        if (!RESETn) begin
            active   = 1'b0;
            late_m   = 1'b0;
            ovf_m    = 1'b0;
            exp_done = 0;
            mq.delete();
            aq.delete();
        end else begin
            busy_m = active && (cyc < exp_done);
            chk("busy", BUSY, busy_m);
            chk("done", DONE, active && (cyc == exp_done));
            chk("late", LATE, late_m);
            chk("overflow", OVERFLOW, ovf_m && (cyc >= exp_done));
            if (OBJ_REQ) begin
                chk("req_expected", busy_m && (aq.size() > 0), 1);
                if (aq.size() > 0) chk("obj_addr", OBJ_ADDR, aq[0]);
                if (int'(OBJ_ADDR) > max_a) max_a = int'(OBJ_ADDR);
            end
            if (DONE && active) chk("all_addr_requested", aq.size(), 0);
            if (Q_VALID) begin
                chk("q_expected", mq.size() > 0, 1);
                if (mq.size() > 0) chk("q_head", {12'd0, Q_PIC, Q_X, Q_ROW}, mq[0]);
            end
            if (HSTART) begin
                late_m = busy_m;
                build_model(VC, PLAYER2);
                active = 1'b1;
                pops   = 0;
                max_a  = 0;
            end else begin
                if (Q_VALID && Q_READY && mq.size() > 0) begin
                    obs_row = mq[0][3:0];
                    void'(mq.pop_front());
                    pops++;
                end
                if (OBJ_REQ && OBJ_ACK && aq.size() > 0) void'(aq.pop_front());
                if (active && cyc == exp_done) active = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge CK1);
        #1;
    endtask

    task automatic set_ram();
        for (int i = 0; i < 32; i++) begin
            ram_y[i]   = 8'h00;
            ram_pic[i] = 8'(8'h40 + i);
            ram_x[i]   = 8'(i * 3);
        end
    endtask

    task automatic start_line(input logic [7:0] vc, input logic fl);
        step();
        VC      = vc;
        PLAYER2 = fl;
        HSTART  = 1'b1;
        step();
        HSTART  = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!DONE && n < 400) begin
            step();
            n++;
        end
        chk(nm, DONE, 1);
    endtask

    initial begin
        RESETn  = 1'b0;
        HSTART  = 1'b0;
        VC      = 8'h00;
        PLAYER2 = 1'b0;
        Q_READY = 1'b0;
        set_ram();
        #1;
        chk("rst_req", OBJ_REQ, 0);
        chk("rst_addr", OBJ_ADDR, 0);
        chk("rst_q", {Q_VALID, Q_PIC, Q_X, Q_ROW}, 0);
        chk("rst_status", {BUSY, DONE, OVERFLOW, LATE}, 0);
        repeat (2) step();
        RESETn = 1'b1;
        repeat (2) step();

        // baseline: only object 5 matches (0x20 + 0xD3 = 0xF3)
        ram_y[5] = 8'hD3;
        Q_READY  = 1'b1;
        start_line(8'h20, 1'b0);
        chk("base_first_addr", OBJ_ADDR, 0);
        chk("base_model_entries", mq.size(), 1);
        chk("base_model_row", mq[0][3:0], 4'h3);
        chk("base_model_done", exp_done - line_k, 64);
        wait_done("base_done_timeout");
        chk("base_overflow", OVERFLOW, 0);
        repeat (3) step();
        chk("base_pops", pops, 1);
        chk("base_row", obs_row, 4'h3);

        // flip: reversed scan order, row complemented
        start_line(8'h20, 1'b1);
        chk("flip_first_addr", OBJ_ADDR, 31);
        chk("flip_model_row", mq[0][3:0], 4'hC);
        wait_done("flip_done_timeout");
        repeat (3) step();
        chk("flip_pops", pops, 1);
        chk("flip_row", obs_row, 4'hC);

        // overflow: every object matches, consumer stalled
        for (int i = 0; i < 32; i++) ram_y[i] = 8'hD3;
        Q_READY = 1'b0;
        start_line(8'h20, 1'b0);
        chk("ovf_model_entries", mq.size(), 8);
        chk("ovf_model_done", exp_done - line_k, 18);
        wait_done("ovf_done_timeout");
        chk("ovf_flag", OVERFLOW, 1);
        chk("ovf_max_addr", max_a, 8);
        Q_READY = 1'b1;
        repeat (12) step();
        chk("ovf_pops", pops, 8);
        chk("ovf_drained", Q_VALID, 0);

        // arbiter stall: three wait cycles per request
        set_ram();
        ram_y[5] = 8'hD3;
        ack_wait = 3;
        start_line(8'h20, 1'b0);
        chk("stall_model_done", exp_done - line_k, 160);
        wait_done("stall_done_timeout");
        repeat (3) step();
        chk("stall_pops", pops, 1);
        chk("stall_row", obs_row, 4'h3);
        ack_wait = 0;

        // mid-scan restart during EVAL of object 10 with a pop offered
        set_ram();
        ram_y[2]  = 8'hD3;
        ram_y[7]  = 8'hD3;
        ram_y[20] = 8'hC5;
        Q_READY   = 1'b0;
        start_line(8'h20, 1'b0);
        begin
            logic [4:0] last;
            logic       found;
            last  = OBJ_ADDR;
            found = 1'b0;
            for (int i = 0; i < 100; i++) begin
                step();
                if (OBJ_REQ) last = OBJ_ADDR;
                else if (BUSY && last == 5'd10) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("restart_found_eval10", found, 1);
        end
        chk("restart_q_before", Q_VALID, 1);
        VC      = 8'h30;
        HSTART  = 1'b1;
        Q_READY = 1'b1;
        step();
        HSTART  = 1'b0;
        Q_READY = 1'b0;
        chk("restart_late", LATE, 1);
        chk("restart_q_empty", Q_VALID, 0);
        chk("restart_req", OBJ_REQ, 1);
        chk("restart_addr", OBJ_ADDR, 0);
        Q_READY = 1'b1;
        wait_done("restart_done_timeout");
        repeat (3) step();
        chk("restart_pops", pops, 1);
        chk("restart_row", obs_row, 4'h5);
        chk("restart_late_sticky", LATE, 1);

        // asynchronous reset while fetching
        start_line(8'h20, 1'b0);
        step();
        step();
        chk("rstmid_in_fetch", OBJ_REQ, 1);
        #2;
        RESETn = 1'b0;
        #1;
        chk("rstmid_outputs",
            {OBJ_REQ, OBJ_ADDR, Q_VALID, Q_PIC, Q_X, Q_ROW, BUSY, DONE, OVERFLOW, LATE}, 0);
        repeat (2) step();
        RESETn = 1'b1;
        repeat (80) step();
        chk("rstmid_idle", {BUSY, DONE, OBJ_REQ}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
